// File: rtl/gbe_rx_mport.sv
// ---------------------------------------------------------------------------
// gbe_rx_mport
//   Receive-side UDP demultiplexer for a gigabit MAC byte stream. It parses
//   Ethernet/IPv4/UDP headers on the fly. It accepts frames addressed to this
//   station (own MAC or broadcast, own IP) whose UDP destination port hits an
//   enabled entry of a small port table. It then forwards the UDP payload,
//   together with the index of the matched table entry and the sender's
//   IP/port.
//
// Optional feature (compile-time macro GBE_RX_STATS_EN):
//   When defined, adds 32-bit frame counters stat_good / stat_drop.
//
// Ports
//   app_clk, app_rst      clock, synchronous active-high reset
//   mac_rx_data/_dvld     incoming frame bytes (dst MAC first, no FCS)
//   mac_rx_goodframe/     one-cycle end-of-frame strobes
//     mac_rx_badframe
//   local_enable          accept new frames
//   local_mac, local_ip   station addresses
//   local_port            N_PORTS x 16-bit UDP port table, entry i at [16i+:16]
//   port_enable           per-entry enable
//   app_rx_data/_dvld     payload bytes, one cycle after the input byte
//   app_rx_port_idx       matched table entry (lowest index wins)
//   app_rx_srcip/_srcport sender address of the current/last frame
//   app_rx_eof            end-of-frame pulse, qualified by app_rx_badframe
//   stat_good, stat_drop  frame counters (GBE_RX_STATS_EN only)
// ---------------------------------------------------------------------------
module gbe_rx_mport #(
    parameter int N_PORTS = 4,
    parameter int PIDX_W  = 2
) (
    input  logic                   app_clk,
    input  logic                   app_rst,
    input  logic [7:0]             mac_rx_data,
    input  logic                   mac_rx_dvld,
    input  logic                   mac_rx_goodframe,
    input  logic                   mac_rx_badframe,
    input  logic                   local_enable,
    input  logic [47:0]            local_mac,
    input  logic [31:0]            local_ip,
    input  logic [16*N_PORTS-1:0]  local_port,
    input  logic [N_PORTS-1:0]     port_enable,
    output logic [7:0]             app_rx_data,
    output logic                   app_rx_dvld,
    output logic [PIDX_W-1:0]      app_rx_port_idx,
    output logic [31:0]            app_rx_srcip,
    output logic [15:0]            app_rx_srcport,
    output logic                   app_rx_eof,
    output logic                   app_rx_badframe
`ifdef GBE_RX_STATS_EN
    ,
    output logic [31:0]            stat_good,
    output logic [31:0]            stat_drop
`endif
);

    typedef enum logic [2:0] {
        ST_SYNC    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_HDR     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_DROP    = 3'd4
    } state_t;

    // Byte i of a 48-bit MAC address, transmitted most significant first.
    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] i);
        logic [7:0] b;
        case (i)
            3'd0:    b = mac[47:40];
            3'd1:    b = mac[39:32];
            3'd2:    b = mac[31:24];
            3'd3:    b = mac[23:16];
            3'd4:    b = mac[15:8];
            3'd5:    b = mac[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Byte i of a 32-bit IPv4 address, most significant first.
    function automatic logic [7:0] ip_byte(input logic [31:0] ip, input logic [1:0] i);
        logic [7:0] b;
        case (i)
            2'd0:    b = ip[31:24];
            2'd1:    b = ip[23:16];
            2'd2:    b = ip[15:8];
            2'd3:    b = ip[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    state_t              state_r;
    state_t              state_nxt_s;

    // cnt_r holds the frame offset of the next byte expected.
    logic [10:0]         cnt_r;
    logic                uc_ok_r;
    logic                bc_ok_r;
    logic [31:0]         srcip_sh_r;
    logic [15:0]         sport_r;
    logic [7:0]          dport_hi_r;
    logic [7:0]          len_hi_r;
    logic [PIDX_W-1:0]   pidx_r;
    logic [15:0]         rem_r;

    logic [7:0]          data_r;
    logic                dvld_r;
    logic [PIDX_W-1:0]   idx_r;
    logic [31:0]         srcip_r;
    logic [15:0]         srcport_r;
    logic                eof_r;
    logic                bad_r;

    logic [10:0]         cur_idx_s;
    logic                uc_base_s;
    logic                bc_base_s;
    logic                uc_ok_s;
    logic                bc_ok_s;
    logic [1:0]          ip_sel_s;
    logic [15:0]         ulen_s;
    logic [15:0]         dport_s;
    logic                port_hit_s;
    logic [PIDX_W-1:0]   port_idx_s;
    logic                byte_ok_s;
    logic                end_s;
    logic                pay_out_s;
    logic                eof_s;
    logic                eof_bad_s;
    logic                hdr_done_s;

    // Header byte checks, port-table lookup and next-state selection.
    always_comb begin
        state_nxt_s = state_r;
        // In IDLE the byte on the bus is offset 0 of a new frame.
        cur_idx_s   = (state_r == ST_IDLE) ? 11'd0 : cnt_r;
        uc_base_s   = (state_r == ST_IDLE) ? 1'b1 : uc_ok_r;
        bc_base_s   = (state_r == ST_IDLE) ? 1'b1 : bc_ok_r;
        uc_ok_s     = uc_base_s;
        bc_ok_s     = bc_base_s;
        // Offsets 30..33 map to IP bytes 0..3, i.e. (offset - 30) mod 4.
        ip_sel_s    = cur_idx_s[1:0] - 2'd2;
        ulen_s      = {len_hi_r, mac_rx_data};
        dport_s     = {dport_hi_r, mac_rx_data};
        port_hit_s  = 1'b0;
        port_idx_s  = {PIDX_W{1'b0}};
        byte_ok_s   = 1'b1;
        end_s       = mac_rx_goodframe | mac_rx_badframe;

        // Scan from the top so the lowest matching index is the one kept.
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            port_idx_s = (port_enable[i] && (local_port[16*i +: 16] == dport_s))
                         ? PIDX_W'(i) : port_idx_s;
            port_hit_s = port_hit_s | (port_enable[i] && (local_port[16*i +: 16] == dport_s));
        end

        if (cur_idx_s < 11'd6) begin
            // Destination must be entirely our MAC or entirely broadcast.
            uc_ok_s   = uc_base_s & (mac_rx_data == mac_byte(local_mac, cur_idx_s[2:0]));
            bc_ok_s   = bc_base_s & (mac_rx_data == 8'hFF);
            byte_ok_s = uc_ok_s | bc_ok_s;
        end else begin
            case (cur_idx_s)
                11'd12:  byte_ok_s = (mac_rx_data == 8'h08);
                11'd13:  byte_ok_s = (mac_rx_data == 8'h00);
                11'd14:  byte_ok_s = (mac_rx_data == 8'h45);
                11'd23:  byte_ok_s = (mac_rx_data == 8'h11);
                11'd30, 11'd31, 11'd32, 11'd33:
                         byte_ok_s = (mac_rx_data == ip_byte(local_ip, ip_sel_s));
                11'd37:  byte_ok_s = port_hit_s;
                11'd39:  byte_ok_s = (ulen_s >= 16'd8);
                default: byte_ok_s = 1'b1;
            endcase
        end

        case (state_r)
            ST_SYNC: begin
                if (end_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_SYNC;
                end
            end
            ST_IDLE: begin
                if (mac_rx_dvld) begin
                    state_nxt_s = (local_enable && byte_ok_s) ? ST_HDR : ST_DROP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (end_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (mac_rx_dvld && !byte_ok_s) begin
                    state_nxt_s = ST_DROP;
                end else if (mac_rx_dvld && (cur_idx_s == 11'd41)) begin
                    state_nxt_s = ST_PAYLOAD;
                end else begin
                    state_nxt_s = ST_HDR;
                end
            end
            ST_PAYLOAD: begin
                if (end_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_PAYLOAD;
                end
            end
            ST_DROP: begin
                if (end_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DROP;
                end
            end
            default: state_nxt_s = ST_SYNC;
        endcase

        pay_out_s  = (state_r == ST_PAYLOAD) && mac_rx_dvld && (rem_r != 16'd0);
        eof_s      = (state_r == ST_PAYLOAD) && end_s;
        // A payload cut short of the UDP length is reported as bad.
        eof_bad_s  = mac_rx_badframe | (rem_r != 16'd0);
        hdr_done_s = (state_r == ST_HDR) && mac_rx_dvld && byte_ok_s && (cur_idx_s == 11'd41);
    end

    // Parser state register.
    always_ff @(posedge app_clk) begin
        if (app_rst) begin
            state_r <= ST_SYNC;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Byte counter, header field capture and payload countdown.
    always_ff @(posedge app_clk) begin
        if (app_rst) begin
            cnt_r      <= 11'd0;
            uc_ok_r    <= 1'b1;
            bc_ok_r    <= 1'b1;
            srcip_sh_r <= 32'd0;
            sport_r    <= 16'd0;
            dport_hi_r <= 8'd0;
            len_hi_r   <= 8'd0;
            pidx_r     <= {PIDX_W{1'b0}};
            rem_r      <= 16'd0;
        end else begin
            if (state_r == ST_IDLE) begin
                cnt_r <= mac_rx_dvld ? 11'd1 : 11'd0;
            end else if (mac_rx_dvld && (cnt_r != 11'd2047)) begin
                cnt_r <= cnt_r + 11'd1;
            end else begin
                cnt_r <= cnt_r;
            end

            if (mac_rx_dvld && ((state_r == ST_IDLE) || (state_r == ST_HDR))) begin
                uc_ok_r <= uc_ok_s;
                bc_ok_r <= bc_ok_s;
            end

            if (mac_rx_dvld && (state_r == ST_HDR)) begin
                case (cur_idx_s)
                    11'd26, 11'd27, 11'd28, 11'd29:
                             srcip_sh_r <= {srcip_sh_r[23:0], mac_rx_data};
                    11'd34:  sport_r[15:8] <= mac_rx_data;
                    11'd35:  sport_r[7:0]  <= mac_rx_data;
                    11'd36:  dport_hi_r    <= mac_rx_data;
                    11'd37:  pidx_r        <= port_idx_s;
                    11'd38:  len_hi_r      <= mac_rx_data;
                    11'd39:  rem_r         <= ulen_s - 16'd8;
                    default: rem_r         <= rem_r;
                endcase
            end else if (pay_out_s) begin
                rem_r <= rem_r - 16'd1;
            end
        end
    end

    // Registered application-side outputs; frame attributes update as the
    // header completes so they are stable from the first payload byte on.
    always_ff @(posedge app_clk) begin
        if (app_rst) begin
            data_r    <= 8'd0;
            dvld_r    <= 1'b0;
            idx_r     <= {PIDX_W{1'b0}};
            srcip_r   <= 32'd0;
            srcport_r <= 16'd0;
            eof_r     <= 1'b0;
            bad_r     <= 1'b0;
        end else begin
            dvld_r <= pay_out_s;
            eof_r  <= eof_s;
            bad_r  <= eof_s & eof_bad_s;
            if (pay_out_s) begin
                data_r <= mac_rx_data;
            end
            if (hdr_done_s) begin
                idx_r     <= pidx_r;
                srcip_r   <= srcip_sh_r;
                srcport_r <= sport_r;
            end
        end
    end

    assign app_rx_data     = data_r;
    assign app_rx_dvld     = dvld_r;
    assign app_rx_port_idx = idx_r;
    assign app_rx_srcip    = srcip_r;
    assign app_rx_srcport  = srcport_r;
    assign app_rx_eof      = eof_r;
    assign app_rx_badframe = bad_r;

`ifdef GBE_RX_STATS_EN
    logic [31:0] stat_good_r;
    logic [31:0] stat_drop_r;
    logic        drop_end_s;

    // Frames that end before or without reaching the payload count as drops.
    assign drop_end_s = ((state_r == ST_HDR) || (state_r == ST_DROP)) && end_s;

    // Good/dropped frame counters, free-running with natural wrap.
    always_ff @(posedge app_clk) begin
        if (app_rst) begin
            stat_good_r <= 32'd0;
            stat_drop_r <= 32'd0;
        end else begin
            if (eof_s && !eof_bad_s) begin
                stat_good_r <= stat_good_r + 32'd1;
            end
            if (drop_end_s || (eof_s && eof_bad_s)) begin
                stat_drop_r <= stat_drop_r + 32'd1;
            end
        end
    end

    assign stat_good = stat_good_r;
    assign stat_drop = stat_drop_r;
`endif

endmodule

// File: tb/tb_gbe_rx_mport.sv
// ---------------------------------------------------------------------------
// tb_gbe_rx_mport
//   Scoreboard bench for gbe_rx_mport. Frames are built as byte queues; a
//   frame-level reference model decides from the whole frame whether it is
//   accepted and which payload bytes / eof it yields, pushing those into an
//   expectation queue. A monitor pops and compares on every app_rx_dvld or
//   app_rx_eof. Directed frames come first, then randomized ones.
// ---------------------------------------------------------------------------
module tb_gbe_rx_mport;

    localparam int N_PORTS = 4;
    localparam int PIDX_W  = 2;

    logic                  app_clk = 1'b0;
    logic                  app_rst;
    logic [7:0]            mac_rx_data;
    logic                  mac_rx_dvld;
    logic                  mac_rx_goodframe;
    logic                  mac_rx_badframe;
    logic                  local_enable;
    logic [47:0]           local_mac;
    logic [31:0]           local_ip;
    logic [16*N_PORTS-1:0] local_port;
    logic [N_PORTS-1:0]    port_enable;
    logic [7:0]            app_rx_data;
    logic                  app_rx_dvld;
    logic [PIDX_W-1:0]     app_rx_port_idx;
    logic [31:0]           app_rx_srcip;
    logic [15:0]           app_rx_srcport;
    logic                  app_rx_eof;
    logic                  app_rx_badframe;
`ifdef GBE_RX_STATS_EN
    logic [31:0]           stat_good;
    logic [31:0]           stat_drop;
`endif

    gbe_rx_mport #(.N_PORTS(N_PORTS), .PIDX_W(PIDX_W)) dut (
        .app_clk          (app_clk),
        .app_rst          (app_rst),
        .mac_rx_data      (mac_rx_data),
        .mac_rx_dvld      (mac_rx_dvld),
        .mac_rx_goodframe (mac_rx_goodframe),
        .mac_rx_badframe  (mac_rx_badframe),
        .local_enable     (local_enable),
        .local_mac        (local_mac),
        .local_ip         (local_ip),
        .local_port       (local_port),
        .port_enable      (port_enable),
        .app_rx_data      (app_rx_data),
        .app_rx_dvld      (app_rx_dvld),
        .app_rx_port_idx  (app_rx_port_idx),
        .app_rx_srcip     (app_rx_srcip),
        .app_rx_srcport   (app_rx_srcport),
        .app_rx_eof       (app_rx_eof),
        .app_rx_badframe  (app_rx_badframe)
`ifdef GBE_RX_STATS_EN
        ,
        .stat_good        (stat_good),
        .stat_drop        (stat_drop)
`endif
    );

    always #5 app_clk = ~app_clk;

    typedef struct {
        bit          is_eof;
        logic [7:0]  data;
        logic [1:0]  idx;
        logic [31:0] sip;
        logic [15:0] sport;
        bit          bad;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] frm[$];
    int         checks   = 0;
    int         errors   = 0;
    int         exp_good = 0;
    int         exp_drop = 0;
    bit         gaps_on  = 1'b0;

    localparam logic [47:0] MY_MAC = 48'h02_11_22_33_44_55;
    localparam logic [31:0] MY_IP  = 32'hC0_A8_01_0A;
    localparam logic [47:0] BCAST  = 48'hFFFF_FFFF_FFFF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Assemble an Ethernet/IPv4/UDP frame into frm.
    task automatic build(input logic [47:0] dmac, input logic [15:0] etype,
                         input logic [7:0] vihl, input logic [7:0] proto,
                         input logic [31:0] sip, input logic [31:0] dip,
                         input logic [15:0] sp, input logic [15:0] dp,
                         input logic [15:0] ulen, input int npay, input bit pad);
        frm.delete();
        for (int i = 5; i >= 0; i--) frm.push_back(dmac[8*i +: 8]);
        for (int i = 0; i < 6; i++) frm.push_back(8'($urandom()));
        frm.push_back(etype[15:8]);
        frm.push_back(etype[7:0]);
        frm.push_back(vihl);
        for (int i = 15; i < 23; i++) frm.push_back(8'($urandom()));
        frm.push_back(proto);
        frm.push_back(8'($urandom()));
        frm.push_back(8'($urandom()));
        for (int i = 3; i >= 0; i--) frm.push_back(sip[8*i +: 8]);
        for (int i = 3; i >= 0; i--) frm.push_back(dip[8*i +: 8]);
        frm.push_back(sp[15:8]);
        frm.push_back(sp[7:0]);
        frm.push_back(dp[15:8]);
        frm.push_back(dp[7:0]);
        frm.push_back(ulen[15:8]);
        frm.push_back(ulen[7:0]);
        frm.push_back(8'($urandom()));
        frm.push_back(8'($urandom()));
        for (int i = 0; i < npay; i++) frm.push_back(8'($urandom()));
        if (pad) begin
            while (frm.size() < 60) frm.push_back(8'h00);
        end
    endtask

    task automatic push_data(input logic [7:0] d, input logic [1:0] idx,
                             input logic [31:0] sip, input logic [15:0] sp);
        ev_t e;
        e.is_eof = 1'b0; e.data = d; e.idx = idx; e.sip = sip; e.sport = sp; e.bad = 1'b0;
        exp_q.push_back(e);
    endtask

    // Frame-level reference: decide acceptance from whole-frame fields.
    task automatic model_frame(input bit en0, input bit bad_strobe);
        bit          ok;
        int          hit;
        int          avail;
        int          n;
        int          emit;
        logic [47:0] dmac;
        logic [31:0] dip;
        logic [31:0] sip;
        logic [15:0] dp;
        logic [15:0] sp;
        logic [15:0] ulen;
        ev_t         e;
        ok  = en0 && (frm.size() >= 42);
        hit = -1;
        if (ok) begin
            dmac = {frm[0], frm[1], frm[2], frm[3], frm[4], frm[5]};
            sip  = {frm[26], frm[27], frm[28], frm[29]};
            dip  = {frm[30], frm[31], frm[32], frm[33]};
            sp   = {frm[34], frm[35]};
            dp   = {frm[36], frm[37]};
            ulen = {frm[38], frm[39]};
            for (int i = 0; i < N_PORTS; i++)
                if (hit < 0 && port_enable[i] && local_port[16*i +: 16] == dp) hit = i;
            ok = (dmac == local_mac || dmac == BCAST) && ({frm[12], frm[13]} == 16'h0800)
                 && (frm[14] == 8'h45) && (frm[23] == 8'h11) && (dip == local_ip)
                 && (hit >= 0) && (ulen >= 16'd8);
        end
        if (!ok) begin
            exp_drop++;
            return;
        end
        avail = frm.size() - 42;
        n     = int'(ulen) - 8;
        emit  = (avail < n) ? avail : n;
        for (int k = 0; k < emit; k++) push_data(frm[42+k], 2'(hit), sip, sp);
        e.is_eof = 1'b1; e.data = 8'h00; e.idx = 2'(hit); e.sip = sip; e.sport = sp;
        e.bad    = bad_strobe || (avail < n);
        exp_q.push_back(e);
        if (e.bad) exp_drop++;
        else       exp_good++;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge app_clk);
            #1;
        end
    endtask

    // Drive frm, then an end strobe. Optionally raise local_enable or pulse
    // app_rst (two cycles) at a given byte offset.
    task automatic send_frame(input bit bad, input int raise_at, input int rst_at);
        for (int k = 0; k < frm.size(); k++) begin
            if (gaps_on && $urandom_range(0, 7) == 0) begin
                mac_rx_dvld = 1'b0;
                idle(1);
            end
            if (k == raise_at) local_enable = 1'b1;
            if (rst_at >= 0 && k == rst_at) app_rst = 1'b1;
            if (rst_at >= 0 && k == rst_at + 2) app_rst = 1'b0;
            mac_rx_data = frm[k];
            mac_rx_dvld = 1'b1;
            idle(1);
        end
        mac_rx_dvld = 1'b0;
        mac_rx_data = 8'h00;
        if (bad) mac_rx_badframe = 1'b1;
        else     mac_rx_goodframe = 1'b1;
        idle(1);
        mac_rx_badframe  = 1'b0;
        mac_rx_goodframe = 1'b0;
        idle(2);
    endtask

    // Scoreboard monitor.
    always @(negedge app_clk) begin
        ev_t e;
        if (app_rx_dvld === 1'b1 || app_rx_eof === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got dvld=%0b eof=%0b expected none",
                         app_rx_dvld, app_rx_eof);
            end else begin
                e = exp_q.pop_front();
                check("out_eof", {31'd0, app_rx_eof}, {31'd0, e.is_eof});
                check("out_dvld", {31'd0, app_rx_dvld}, {31'd0, !e.is_eof});
                if (!e.is_eof) check("out_data", {24'd0, app_rx_data}, {24'd0, e.data});
                else           check("out_bad", {31'd0, app_rx_badframe}, {31'd0, e.bad});
                check("out_idx", {30'd0, app_rx_port_idx}, {30'd0, e.idx});
                check("out_srcip", app_rx_srcip, e.sip);
                check("out_srcport", {16'd0, app_rx_srcport}, {16'd0, e.sport});
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] sip;
        logic [15:0] sp;
        logic [15:0] dp;
        logic [15:0] ulen;
        int          kind;
        int          npay;
        bit          pad;
        bit          bad;
        bit          en;
        logic [47:0] dmac;
        logic [15:0] etype;
        logic [7:0]  proto;
        logic [31:0] dip;
        int          cut;

        app_rst = 1'b1; mac_rx_data = 8'h00; mac_rx_dvld = 1'b0;
        mac_rx_goodframe = 1'b0; mac_rx_badframe = 1'b0; local_enable = 1'b1;
        local_mac = MY_MAC; local_ip = MY_IP;
        local_port = {16'h5000, 16'h1234, 16'h5000, 16'h0777};
        port_enable = 4'b1111;
        idle(3);
        check("rst_data", {24'd0, app_rx_data}, 32'd0);
        check("rst_dvld", {31'd0, app_rx_dvld}, 32'd0);
        check("rst_idx", {30'd0, app_rx_port_idx}, 32'd0);
        check("rst_srcip", app_rx_srcip, 32'd0);
        check("rst_srcport", {16'd0, app_rx_srcport}, 32'd0);
        check("rst_eof", {31'd0, app_rx_eof}, 32'd0);
        check("rst_bad", {31'd0, app_rx_badframe}, 32'd0);
`ifdef GBE_RX_STATS_EN
        check("rst_stat_good", stat_good, 32'd0);
        check("rst_stat_drop", stat_drop, 32'd0);
`endif
        app_rst = 1'b0;

        // Out of reset the parser resyncs: this valid frame must vanish.
        build(MY_MAC, 16'h0800, 8'h45, 8'h11, 32'h0A000001, MY_IP, 16'h1111, 16'h1234, 16'd12, 4, 1'b0);
        send_frame(1'b0, -1, -1);

        // Entry 2, four payload bytes.
        build(MY_MAC, 16'h0800, 8'h45, 8'h11, 32'h0A000002, MY_IP, 16'hABCD, 16'h1234, 16'd12, 4, 1'b0);
        model_frame(1'b1, 1'b0);
        send_frame(1'b0, -1, -1);

        // Padded 60-byte frame carrying two payload bytes.
        build(MY_MAC, 16'h0800, 8'h45, 8'h11, 32'h0A000003, MY_IP, 16'h2222, 16'h0777, 16'd10, 2, 1'b1);
        model_frame(1'b1, 1'b0);
        send_frame(1'b0, -1, -1);

        // Wrong destination IP (last byte), then a disabled port entry.
        build(MY_MAC, 16'h0800, 8'h45, 8'h11, 32'h0A000004, MY_IP ^ 32'h1, 16'h3333, 16'h1234, 16'd12, 4, 1'b1);
        model_frame(1'b1, 1'b0);
        send_frame(1'b0, -1, -1);
        port_enable = 4'b1011;
        build(MY_MAC, 16'h0800, 8'h45, 8'h11, 32'h0A000005, MY_IP, 16'h4444, 16'h1234, 16'd12, 4, 1'b1);
        model_frame(1'b1, 1'b0);
        send_frame(1'b0, -1, -1);
        port_enable = 4'b1111;
`ifdef GBE_RX_STATS_EN
        check("stat_drop_mid", stat_drop, 32'(exp_drop));
        check("stat_good_mid", stat_good, 32'(exp_good));
`endif

        // Broadcast to a port held by entries 1 and 3, ended with badframe.
        build(BCAST, 16'h0800, 8'h45, 8'h11, 32'h0A000006, MY_IP, 16'h5555, 16'h5000, 16'd14, 6, 1'b1);
        model_frame(1'b1, 1'b1);
        send_frame(1'b1, -1, -1);

        // Disabled at frame start, enabled mid-frame; the next one is taken.
        local_enable = 1'b0;
        build(MY_MAC, 16'h0800, 8'h45, 8'h11, 32'h0A000007, MY_IP, 16'h6666, 16'h1234, 16'd12, 4, 1'b0);
        model_frame(1'b0, 1'b0);
        send_frame(1'b0, 10, -1);
        build(MY_MAC, 16'h0800, 8'h45, 8'h11, 32'h0A000008, MY_IP, 16'h7777, 16'h1234, 16'd11, 3, 1'b0);
        model_frame(1'b1, 1'b0);
        send_frame(1'b0, -1, -1);

        // UDP length 8: no payload, eof only.
        build(MY_MAC, 16'h0800, 8'h45, 8'h11, 32'h0A000009, MY_IP, 16'h8888, 16'h1234, 16'd8, 0, 1'b1);
        model_frame(1'b1, 1'b0);
        send_frame(1'b0, -1, -1);

        // Reset lands on payload byte 3: bytes 0..2 have already left the
        // block, nothing more of this frame may appear, next frame is intact.
        build(MY_MAC, 16'h0800, 8'h45, 8'h11, 32'h0A00000A, MY_IP, 16'h9999, 16'h1234, 16'd16, 8, 1'b0);
        for (int k = 0; k < 3; k++) push_data(frm[42+k], 2'd2, 32'h0A00000A, 16'h9999);
        exp_good = 0;
        exp_drop = 0;
        send_frame(1'b0, -1, 45);
        build(MY_MAC, 16'h0800, 8'h45, 8'h11, 32'h0A00000B, MY_IP, 16'hAAAA, 16'h1234, 16'd13, 5, 1'b0);
        model_frame(1'b1, 1'b0);
        send_frame(1'b0, -1, -1);

        // Randomized frames.
        gaps_on = 1'b1;
        for (int f = 0; f < 48; f++) begin
            kind  = $urandom_range(0, 12);
            dmac  = MY_MAC; etype = 16'h0800; proto = 8'h11; dip = MY_IP;
            sip   = $urandom(); sp = 16'($urandom());
            dp    = local_port[16*$urandom_range(0, 3) +: 16];
            ulen  = 16'(8 + $urandom_range(0, 20));
            npay  = int'(ulen) - 8; pad = 1'b1; bad = 1'b0; en = 1'b1; cut = -1;
            port_enable = 4'($urandom_range(1, 15));
            case (kind)
                2:       dmac = BCAST;
                3:       dmac = MY_MAC ^ 48'h0000_0100_0000;
                4:       etype = 16'h86DD;
                5:       proto = 8'h06;
                6:       dip = MY_IP ^ 32'h0001_0000;
                7:       dp = 16'hBEEF;
                8:       begin ulen = 16'($urandom_range(0, 7)); npay = 4; end
                9:       begin ulen = 16'(9 + $urandom_range(0, 20)); npay = int'(ulen) - 9; pad = 1'b0; end
                10:      bad = 1'b1;
                11:      en = 1'b0;
                12:      cut = $urandom_range(1, 41);
                default: bad = 1'b0;
            endcase
            build(dmac, etype, 8'h45, proto, sip, dip, sp, dp, ulen, npay, pad);
            if (cut > 0) begin
                while (frm.size() > cut) void'(frm.pop_back());
            end
            local_enable = en;
            model_frame(en, bad);
            send_frame(bad, en ? -1 : 5, -1);
            local_enable = 1'b1;
        end

        idle(10);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
`ifdef GBE_RX_STATS_EN
        check("stat_good_end", stat_good, 32'(exp_good));
        check("stat_drop_end", stat_drop, 32'(exp_drop));
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
